// File: rtl/hdmi_vtg.sv
// hdmi_vtg: parametrised video timing generator for the HDMI output path.
// Produces screen coordinates, sync, blank and frame pulses in the pixel
// clock domain. A run/drain FSM starts and stops video only on frame
// boundaries, so the sink never sees a truncated frame.
// Optional feature macro: HDMI_VTG_PIX_ALIGN_EN. When defined, sync, blank
// and the frame pulses are delayed a further PIX_LAT clocks to line up with
// a pipelined pixel generator.

module hdmi_vtg #(
    parameter int   HSCREEN       = 1280,
    parameter int   HFP           = 110,
    parameter int   HSW           = 40,
    parameter int   HBP           = 220,
    parameter int   VSCREEN       = 720,
    parameter int   VFP           = 5,
    parameter int   VSW           = 5,
    parameter int   VBP           = 20,
    parameter logic HSYNC_POL     = 1'b1,
    parameter logic VSYNC_POL     = 1'b1,
    parameter int   CW            = 12,
    parameter int   MFRAM_CNT_MAX = 60,
    parameter int   PIX_LAT       = 2
) (
    input  logic          clk_pix,
    input  logic          arst,
    input  logic          run,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start,
    output logic          frame_done,
    output logic          mfram_done,
    output logic          busy
);

    localparam int HFRAME = HSCREEN + HFP + HSW + HBP;
    localparam int VFRAME = VSCREEN + VFP + VSW + VBP;

    localparam logic [CW-1:0] H_LAST     = CW'(HFRAME - 1);
    localparam logic [CW-1:0] H_VIS      = CW'(HSCREEN);
    localparam logic [CW-1:0] H_VIS_LAST = CW'(HSCREEN - 1);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(HSCREEN + HFP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(HSCREEN + HFP + HSW);

    localparam logic [CW-1:0] V_LAST     = CW'(VFRAME - 1);
    localparam logic [CW-1:0] V_VIS      = CW'(VSCREEN);
    localparam logic [CW-1:0] V_VIS_LAST = CW'(VSCREEN - 1);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(VSCREEN + VFP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(VSCREEN + VFP + VSW);

    localparam int            MW      = (MFRAM_CNT_MAX > 1) ? $clog2(MFRAM_CNT_MAX) : 1;
    localparam logic [MW-1:0] MF_LAST = MW'(MFRAM_CNT_MAX - 1);

    // Packed order of the delayed signal group: {hsync, vsync, blank, frame_done, mfram_done}
    localparam logic [4:0] SIG_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b1, 1'b0, 1'b0};

`ifdef HDMI_VTG_PIX_ALIGN_EN
    localparam int DLY_DEPTH = PIX_LAT;
`else
    // PIX_LAT has no effect without alignment; it stays referenced so both
    // builds share one parameter list.
    localparam int DLY_DEPTH = 0 * PIX_LAT;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] hcount_nx;
    logic [CW-1:0] vcount_nx;
    logic [MW-1:0] mfram_cnt;
    logic [4:0]    sig_r;
    logic [4:0]    sig_o;

    logic counting;
    logic h_wrap;
    logic v_wrap;
    logic frame_wrap;
    logic h_sync_rgn;
    logic v_sync_rgn;
    logic visible;
    logic hsync_d;
    logic vsync_d;
    logic blank_d;
    logic fdone_d;
    logic mdone_d;

    assign counting   = (state != ST_IDLE);
    assign h_wrap     = (hcount == H_LAST);
    assign v_wrap     = (vcount == V_LAST);
    assign frame_wrap = h_wrap && v_wrap;

    assign h_sync_rgn = (hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END);
    assign v_sync_rgn = (vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END);
    assign visible    = (hcount < H_VIS) && (vcount < V_VIS);

    // Decoded timing for the coordinates presented this cycle; IDLE forces inactive values.
    assign hsync_d = (counting && h_sync_rgn) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync_d = (counting && v_sync_rgn) ? VSYNC_POL : ~VSYNC_POL;
    assign blank_d = ~(counting && visible);
    assign fdone_d = counting && (hcount == H_VIS_LAST) && (vcount == V_VIS_LAST);
    assign mdone_d = fdone_d && (mfram_cnt == MF_LAST);

    // Next state and next coordinates; counters only move outside IDLE and wrap by compare.
    always_comb begin
        state_nx  = state;
        hcount_nx = hcount;
        vcount_nx = vcount;

        case (state)
            ST_IDLE:  if (run) state_nx = ST_RUN;
            ST_RUN:   if (!run) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (run)
                    state_nx = ST_RUN;
                else if (frame_wrap)
                    state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase

        if (counting) begin
            hcount_nx = h_wrap ? '0 : hcount + CW'(1);
            if (h_wrap)
                vcount_nx = v_wrap ? '0 : vcount + CW'(1);
        end else begin
            hcount_nx = '0;
            vcount_nx = '0;
        end
    end

    // FSM, coordinate registers, start pulses, multi-frame counter and the 1-cycle decode stage.
    always_ff @(posedge clk_pix or posedge arst) begin
        if (arst) begin
            state       <= ST_IDLE;
            hcount      <= '0;
            vcount      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            mfram_cnt   <= '0;
            sig_r       <= SIG_IDLE;
        end else begin
            state       <= state_nx;
            hcount      <= hcount_nx;
            vcount      <= vcount_nx;
            line_start  <= (state_nx != ST_IDLE) && (hcount_nx == '0);
            frame_start <= (state_nx != ST_IDLE) && (hcount_nx == '0) && (vcount_nx == '0);
            sig_r       <= {hsync_d, vsync_d, blank_d, fdone_d, mdone_d};

            if (state_nx == ST_IDLE)
                mfram_cnt <= '0;
            else if (fdone_d)
                mfram_cnt <= mdone_d ? '0 : mfram_cnt + MW'(1);
        end
    end

    // mfram_done travels with frame_done through the delay so the two stay coincident.
    generate
        if (DLY_DEPTH == 0) begin : g_no_dly
            assign sig_o = sig_r;
        end else begin : g_dly
            logic [4:0] dly [DLY_DEPTH];

            // Alignment shift register, flushed to inactive values on reset.
            always_ff @(posedge clk_pix or posedge arst) begin
                if (arst) begin
                    for (int i = 0; i < DLY_DEPTH; i++)
                        dly[i] <= SIG_IDLE;
                end else begin
                    dly[0] <= sig_r;
                    for (int i = 1; i < DLY_DEPTH; i++)
                        dly[i] <= dly[i-1];
                end
            end

            assign sig_o = dly[DLY_DEPTH-1];
        end
    endgenerate

    assign {hsync, vsync, blank, frame_done, mfram_done} = sig_o;
    assign video_on = ~blank;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_hdmi_vtg.sv
// Directed testbench for hdmi_vtg in a small 14x8 geometry
// (visible 8x4, hsync x in [10,13), vsync lines 5..6, 112 clocks per frame).
// Expected positions are hand-derived per cycle; delayed outputs are taken
// from the position presented LAT cycles earlier.

module tb_hdmi_vtg;

    localparam int PIX_LAT_TB = 3;
    localparam int HFR        = 14;
    localparam int FRAME_LEN  = 112;
`ifdef HDMI_VTG_PIX_ALIGN_EN
    localparam int LAT = PIX_LAT_TB + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk_pix;
    logic        arst;
    logic        run;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        video_on;
    logic        line_start;
    logic        frame_start;
    logic        frame_done;
    logic        mfram_done;
    logic        busy;

    int n_compared;
    int n_mismatched;
    int fd_count;
    bit hv [0:16];
    int hp [0:16];

    int first_fd;
    int fd_seen;
    int m1;
    int m2;
    int fs1;
    int fs2;

    hdmi_vtg #(
        .HSCREEN(8), .HFP(2), .HSW(3), .HBP(1),
        .VSCREEN(4), .VFP(1), .VSW(2), .VBP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .CW(12), .MFRAM_CNT_MAX(3), .PIX_LAT(PIX_LAT_TB)
    ) dut (
        .clk_pix(clk_pix),
        .arst(arst),
        .run(run),
        .hcount(hcount),
        .vcount(vcount),
        .hsync(hsync),
        .vsync(vsync),
        .blank(blank),
        .video_on(video_on),
        .line_start(line_start),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .mfram_done(mfram_done),
        .busy(busy)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    task automatic applyStimulus(input logic r, input logic a);
        run  = r;
        arst = a;
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearHistory();
        for (int i = 0; i <= 16; i++) begin
            hv[i] = 1'b0;
            hp[i] = 0;
        end
        fd_count = 0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".hcount"},      int'(hcount), 0);
        checkOutput({tag, ".vcount"},      int'(vcount), 0);
        checkOutput({tag, ".hsync"},       int'(hsync), 0);
        checkOutput({tag, ".vsync"},       int'(vsync), 0);
        checkOutput({tag, ".blank"},       int'(blank), 1);
        checkOutput({tag, ".video_on"},    int'(video_on), 0);
        checkOutput({tag, ".line_start"},  int'(line_start), 0);
        checkOutput({tag, ".frame_start"}, int'(frame_start), 0);
        checkOutput({tag, ".frame_done"},  int'(frame_done), 0);
        checkOutput({tag, ".mfram_done"},  int'(mfram_done), 0);
        checkOutput({tag, ".busy"},        int'(busy), 0);
    endtask

    // v: a running state presents position p (0..111) this cycle; v=0 means IDLE at (0,0).
    task automatic checkCycle(input bit v, input int p);
        int x, y, dx, dy;
        bit dv, hs, vs, bl, fd, md;
        for (int i = 16; i > 0; i--) begin
            hv[i] = hv[i-1];
            hp[i] = hp[i-1];
        end
        hv[0] = v;
        hp[0] = p;
        x = v ? p % HFR : 0;
        y = v ? p / HFR : 0;
        checkOutput("hcount",      int'(hcount), x);
        checkOutput("vcount",      int'(vcount), y);
        checkOutput("busy",        int'(busy), int'(v));
        checkOutput("line_start",  int'(line_start), int'(v && x == 0));
        checkOutput("frame_start", int'(frame_start), int'(v && p == 0));

        dv = hv[LAT];
        dx = hp[LAT] % HFR;
        dy = hp[LAT] / HFR;
        hs = dv && dx >= 10 && dx < 13;
        vs = dv && dy >= 5 && dy < 7;
        bl = !(dv && dx < 8 && dy < 4);
        fd = dv && hp[LAT] == 49;
        if (!v)
            fd_count = 0;
        if (fd)
            fd_count++;
        md = fd && (fd_count % 3 == 0);
        checkOutput("hsync",      int'(hsync), int'(hs));
        checkOutput("vsync",      int'(vsync), int'(vs));
        checkOutput("blank",      int'(blank), int'(bl));
        checkOutput("video_on",   int'(video_on), int'(!bl));
        checkOutput("frame_done", int'(frame_done), int'(fd));
        checkOutput("mfram_done", int'(mfram_done), int'(md));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        first_fd     = -1;
        fd_seen      = 0;
        m1 = -1; m2 = -1; fs1 = -1; fs2 = -1;
        clearHistory();

        // Reset values before any clock edge, then idle with run low.
        applyStimulus(1'b0, 1'b1);
        #3;
        checkReset("reset");
        repeat (2) @(posedge clk_pix);
        #1;
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            tick();
            checkCycle(1'b0, 0);
        end

        // Continuous run for six frames, drop run at (5,2) of the seventh.
        $display("[TB] continuous run and drain to idle");
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c <= 6 * FRAME_LEN + 111; c++) begin
            tick();
            checkCycle(1'b1, c % FRAME_LEN);
            if (frame_done === 1'b1) begin
                fd_seen++;
                if (first_fd < 0) first_fd = c;
            end
            if (mfram_done === 1'b1) begin
                if (m1 < 0) m1 = c;
                else if (m2 < 0) m2 = c;
            end
            if (frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = c;
                else if (fs2 < 0) fs2 = c;
            end
            if (c == 6 * FRAME_LEN + 33)
                applyStimulus(1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checkCycle(1'b0, 0);
        end
        checkOutput("first_frame_done_cycle", first_fd, 49 + LAT);
        checkOutput("first_mfram_done_cycle", m1, 273 + LAT);
        checkOutput("mfram_done_period", m2 - m1, 336);
        checkOutput("frame_start_period", fs2 - fs1, 112);
        checkOutput("frame_done_count", fd_seen, 7);

        // Drop run at (5,2), re-raise at (5,6): no idle, no gap; reset at (9,5) of the next frame.
        $display("[TB] drain cancelled, then async reset mid-frame");
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c <= FRAME_LEN + 79; c++) begin
            tick();
            checkCycle(1'b1, c % FRAME_LEN);
            if (c == 33) applyStimulus(1'b0, 1'b0);
            if (c == 89) applyStimulus(1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1);
        #1;
        checkReset("async_reset");
        clearHistory();
        repeat (2) @(posedge clk_pix);
        #1;
        checkReset("held_reset");
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c <= FRAME_LEN + 30; c++) begin
            tick();
            checkCycle(1'b1, c % FRAME_LEN);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
